// File: rtl/gf2_pkg.sv
// gf2_pkg: shared types and widths for the GF(2) multiplier datapath
package gf2_pkg;
  localparam int A_ROWS = 4;
  localparam int A_COLS = 8;
  localparam int B_COLS = 1;
  localparam int ROW_IDX_W = $clog2(A_ROWS);
  localparam int BEAT_CNT_W = $clog2(A_COLS);
  typedef enum logic {FILL, STALL} loader_state_e;
endpackage

// File: rtl/gf2_operand_loader_if.sv
// gf2_operand_loader_if: beat stream in, operand pair out
interface gf2_operand_loader_if #(
  parameter int A_ROWS = gf2_pkg::A_ROWS,
  parameter int A_COLS = gf2_pkg::A_COLS,
  parameter int B_COLS = gf2_pkg::B_COLS
);
  logic                     s_valid;
  logic                     s_ready;
  logic [B_COLS-1:0]        s_data;
  logic                     m_valid;
  logic                     m_ready;
  logic [A_ROWS*A_COLS-1:0] A_data_out;
  logic [A_COLS*B_COLS-1:0] B_data_out;
  modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, A_data_out, B_data_out);
  modport slave (input s_valid, s_data, m_ready, output s_ready, m_valid, A_data_out, B_data_out);
endinterface

// File: rtl/gf2_row_bank.sv
// gf2_row_bank: ROWS x COLS register file, indexed row write, flat read
module gf2_row_bank #(
  parameter int ROWS = 4,
  parameter int COLS = 8,
  localparam int RW = $clog2(ROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [RW-1:0]        wr_row,
  input  logic [COLS-1:0]      wr_data,
  output logic [ROWS*COLS-1:0] rd_data
);
  logic [ROWS*COLS-1:0] bank_q, bank_d;
  // Only indices below ROWS can match, so out-of-range writes are dropped
  always_comb begin
    bank_d = bank_q;
    for (int r = 0; r < ROWS; r++)
      if (wr_en && wr_row == RW'(r)) bank_d[r*COLS +: COLS] = wr_data;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) bank_q <= '0;
    else bank_q <= bank_d;
  assign rd_data = bank_q;
endmodule

// File: rtl/gf2_operand_loader.sv
// gf2_operand_loader: collects B beats, snapshots {A, B} for the multiplier.
// GF2_LOADER_MSB_FIRST_EN: first beat lands in the highest B row.
module gf2_operand_loader
  import gf2_pkg::*;
#(
  parameter int A_ROWS = gf2_pkg::A_ROWS,
  parameter int A_COLS = gf2_pkg::A_COLS,
  parameter int B_COLS = gf2_pkg::B_COLS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      a_wr_en,
  input  logic [$clog2(A_ROWS)-1:0] a_wr_row,
  input  logic [A_COLS-1:0]         a_wr_data,
  gf2_operand_loader_if.slave       bus
);
  localparam int CW = $clog2(A_COLS);
  loader_state_e            state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d, idx;
  logic [A_COLS*B_COLS-1:0] fill_q, fill_d, b_out_q, b_out_d;
  logic [A_ROWS*A_COLS-1:0] a_out_q, a_out_d, bank;
  logic                     m_valid_q, m_valid_d, last, snap;
  gf2_row_bank #(.ROWS(A_ROWS), .COLS(A_COLS)) u_bank (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_row(a_wr_row),
    .wr_data(a_wr_data), .rd_data(bank)
  );
`ifdef GF2_LOADER_MSB_FIRST_EN
  assign idx = CW'(A_COLS-1) - cnt_q;
`else
  assign idx = cnt_q;
`endif
  assign last = cnt_q == CW'(A_COLS-1);
  // bank is the pre-write A, so a same-cycle write misses this snapshot
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    fill_d = fill_q;
    snap = 1'b0;
    if (state_q == FILL) begin
      if (flush) cnt_d = '0;
      else if (bus.s_valid) begin
        fill_d[idx*B_COLS +: B_COLS] = bus.s_data;
        cnt_d = last ? '0 : cnt_q + 1'b1;
        snap = last && (!m_valid_q || bus.m_ready);
        state_d = (last && !snap) ? STALL : FILL;
      end
    end else if (flush) begin
      state_d = FILL;
      cnt_d = '0;
    end else if (bus.m_ready) begin
      snap = 1'b1;
      state_d = FILL;
    end
    a_out_d = snap ? bank : a_out_q;
    b_out_d = snap ? fill_d : b_out_q;
    m_valid_d = snap || (m_valid_q && !bus.m_ready);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= FILL;
      cnt_q <= '0;
      fill_q <= '0;
      a_out_q <= '0;
      b_out_q <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fill_q <= fill_d;
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
      m_valid_q <= m_valid_d;
    end
  assign bus.s_ready = state_q == FILL;
  assign bus.m_valid = m_valid_q;
  assign bus.A_data_out = a_out_q;
  assign bus.B_data_out = b_out_q;
endmodule

// File: tb/tb_gf2_operand_loader.sv
// tb_gf2_operand_loader: directed scenarios plus random traffic against a queue-based model
module tb_gf2_operand_loader;
  logic       clk = 0, rst = 0, flush = 0, a_wr_en = 0;
  logic [1:0] a_wr_row = 0;
  logic [7:0] a_wr_data = 0;
  int tests = 0, fails = 0;
`ifdef GF2_LOADER_MSB_FIRST_EN
  localparam logic [7:0] T1_B = 8'hB1;
`else
  localparam logic [7:0] T1_B = 8'h8D;
`endif
  gf2_operand_loader_if bus ();
  gf2_operand_loader dut (
    .clk(clk), .rst(rst), .flush(flush), .a_wr_en(a_wr_en),
    .a_wr_row(a_wr_row), .a_wr_data(a_wr_data), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
    end
  endtask

  // Model: A rows, beats collected so far, one parked full vector, output slot
  logic [7:0]  ma [4];
  bit          beats [$];
  bit          pend_full, mv, m_snap;
  logic [7:0]  pend_vec, m_vec, ob;
  logic [31:0] oa;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      foreach (ma[i]) ma[i] = 8'h00;
      beats.delete();
      pend_full = 0;
      mv = 0;
      oa = 0;
      ob = 0;
    end else begin
      m_snap = 0;
      if (pend_full) begin
        if (flush) pend_full = 0;
        else if (bus.m_ready) begin
          m_snap = 1;
          m_vec = pend_vec;
          pend_full = 0;
        end
      end else if (flush) beats.delete();
      else if (bus.s_valid) begin
        beats.push_back(bus.s_data[0]);
        if (beats.size() == 8) begin
          m_vec = 0;
          for (int k = 0; k < 8; k++)
`ifdef GF2_LOADER_MSB_FIRST_EN
            m_vec[7-k] = beats[k];
`else
            m_vec[k] = beats[k];
`endif
          beats.delete();
          if (!mv || bus.m_ready) m_snap = 1;
          else begin
            pend_vec = m_vec;
            pend_full = 1;
          end
        end
      end
      if (m_snap) begin
        oa = {ma[3], ma[2], ma[1], ma[0]};
        ob = m_vec;
        mv = 1;
      end else if (bus.m_ready) mv = 0;
      if (a_wr_en) ma[a_wr_row] = a_wr_data;
    end
  end

  always @(negedge clk)
    if (rst) begin
      chk("s_ready", bus.s_ready, !pend_full);
      chk("m_valid", bus.m_valid, mv);
      chk("A_data_out", bus.A_data_out, oa);
      chk("B_data_out", bus.B_data_out, ob);
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(bit b);
    bus.s_valid = 1;
    bus.s_data = b;
    tick();
  endtask

  logic [7:0] v;
  initial begin
    bus.s_valid = 0;
    bus.s_data = 0;
    bus.m_ready = 0;
    repeat (2) tick();
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_A", bus.A_data_out, 0);
    chk("rst_B", bus.B_data_out, 0);
    rst = 1;
    tick();
    for (int r = 0; r < 4; r++) begin
      a_wr_en = 1;
      a_wr_row = 2'(r);
      a_wr_data = 8'h01 << r;
      tick();
    end
    a_wr_en = 0;
    bus.m_ready = 1;
    v = 8'h8D;
    for (int k = 0; k < 8; k++) send(v[k]);
    chk("t1_m_valid", bus.m_valid, 1);
    chk("t1_B", bus.B_data_out, T1_B);
    chk("t1_A", bus.A_data_out, 32'h08040201);
    for (int n = 0; n < 2; n++) begin
      v = n ? 8'h00 : 8'hFF;
      for (int k = 0; k < 8; k++) begin
        send(v[k]);
        chk("t2_s_ready", bus.s_ready, 1);
        if (k == 0) chk("t2_m_valid_low", bus.m_valid, 0);
      end
      chk("t2_m_valid", bus.m_valid, 1);
      chk("t2_B", bus.B_data_out, v);
    end
    bus.s_valid = 0;
    tick();
    bus.m_ready = 0;
    for (int n = 0; n < 2; n++) begin
      v = n ? 8'hC3 : 8'h3C;
      for (int k = 0; k < 8; k++) send(v[k]);
    end
    chk("t3_stall_s_ready", bus.s_ready, 0);
    chk("t3_hold_B", bus.B_data_out, 8'h3C);
    repeat (3) tick();
    chk("t3_hold_B2", bus.B_data_out, 8'h3C);
    chk("t3_hold_valid", bus.m_valid, 1);
    bus.s_valid = 0;
    bus.m_ready = 1;
    tick();
    chk("t3_second_B", bus.B_data_out, 8'hC3);
    chk("t3_second_valid", bus.m_valid, 1);
    chk("t3_refill", bus.s_ready, 1);
    tick();
    chk("t3_drained", bus.m_valid, 0);
    v = 8'h5A;
    for (int k = 0; k < 7; k++) send(v[k]);
    a_wr_en = 1;
    a_wr_row = 2;
    a_wr_data = 8'hAA;
    send(v[7]);
    a_wr_en = 0;
    chk("t4_old_row", bus.A_data_out, 32'h08040201);
    for (int k = 0; k < 8; k++) send(0);
    chk("t4_new_row", bus.A_data_out, 32'h08AA0201);
    repeat (3) send(0);
    flush = 1;
    send(0);
    flush = 0;
    for (int k = 0; k < 8; k++) send(1);
    chk("t5_flush_B", bus.B_data_out, 8'hFF);
    repeat (3) send(1);
    rst = 0;
    #1;
    chk("t5_rst_valid", bus.m_valid, 0);
    chk("t5_rst_A", bus.A_data_out, 0);
    chk("t5_rst_B", bus.B_data_out, 0);
    chk("t5_rst_s_ready", bus.s_ready, 1);
    bus.s_valid = 0;
    tick();
    rst = 1;
    tick();
    for (int i = 0; i < 3000; i++) begin
      bus.s_valid = $urandom_range(0, 3) != 0;
      bus.s_data = 1'($urandom);
      bus.m_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 19) == 0;
      a_wr_en = $urandom_range(0, 7) == 0;
      a_wr_row = 2'($urandom);
      a_wr_data = 8'($urandom);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
